std_fp_mult_arbiter: RTL and testbench
======================================

// Module: std_fp_mult_arbiter
// PURPOSE
//  Shares one pipelined fixed-point multiplier (go/done, 3-cycle latency) among NUM_REQ requesters.
//  - Round-robin arbitration; latches the winner's operands and drives the multiplier's go.
//  - Returns the truncated product with a one-cycle done pulse to the granted requester.
//  - Sits between Calyx-style invoke groups and a single multiplier instance; saves area versus one multiplier per group.
// PARAMETERS
//  WIDTH       4  operand/result width; must match the multiplier
//  NUM_REQ     4  number of requesters, >=2
//  MUL_LAT     3  multiplier go->done latency in cycles
//  WDOG_CYCLES 15 watchdog limit; used only with FP_MULT_ARB_WDOG_EN
// PORTS
//  clk        in  1               clock
//  reset      in  1               asynchronous, active-high
//  req_go     in  NUM_REQ         per-requester go, level, held until req_done
//  req_left   in  NUM_REQ*WIDTH   packed left operands; requester i uses slice [i*WIDTH +: WIDTH]
//  req_right  in  NUM_REQ*WIDTH   packed right operands; same slicing as req_left
//  req_done   out NUM_REQ         one-hot, 1-cycle done pulse
//  req_out    out WIDTH           product of the last completed operation
//  grant      out NUM_REQ         one-hot current owner, 0 when idle
//  mul_left   out WIDTH           operand register to the multiplier
//  mul_right  out WIDTH           operand register to the multiplier
//  mul_go     out 1               multiplier go
//  mul_out    in  WIDTH           multiplier result
//  mul_done   in  1               multiplier done
//  wdog_err   out 1               sticky timeout flag; 0 when FP_MULT_ARB_WDOG_EN is undefined
// BEHAVIOUR
//  Reset (async): state=IDLE; rr_ptr=0. All outputs 0: grant, req_done, req_out, mul_*, wdog_err.
//  FSM states:
//  - IDLE: if any req_go, pick the first set bit at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
//    On that edge: grant<=onehot(i), mul_left/right<=req_left/right[i], mul_go<=1, state<=BUSY.
//  - BUSY: mul_go held 1 and operands held stable. Operand changes on req_* are ignored.
//    On mul_done: req_out<=mul_out, req_done[i]<=1 for one cycle, mul_go<=0, grant<=0.
//    Same edge: rr_ptr<=(i+1)%NUM_REQ, state<=DRAIN.
//  - DRAIN: one cycle with mul_go=0 so the multiplier's done pipeline clears; then IDLE.
//    No grant is issued in DRAIN.
//  Timing:
//  - Latency from req_go rising (arbiter idle) to req_done: 1 + MUL_LAT cycles.
//  - Back-to-back issue rate: one operation per MUL_LAT+2 cycles.
//  - Requester-side rules:
//    - Requester i whose go is still high in the cycle after its req_done is a new request.
//    - That new request competes normally at the next IDLE; rr_ptr now favours the others.
//    - Requester i dropping req_go while granted does not abort; the result is still delivered.
//  Boundary conditions:
//  - All requesters high: grants rotate i, i+1, ... with no starvation.
//  - A single requester is granted every MUL_LAT+2 cycles.
//  - rr_ptr wraps NUM_REQ-1 -> 0.
//  - mul_done outside BUSY is ignored.
//  - req_out holds its value until the next completion; it is not cleared on grant.
//  - Reset mid-BUSY: immediate IDLE with mul_go=0; an in-flight result is discarded, no req_done.
//  Arithmetic: the arbiter does no arithmetic; mul_out is passed through unchanged (fixed-point truncation is done by the multiplier).
// CONFIGURATION
//  FP_MULT_ARB_WDOG_EN defined:
//  - A counter runs in BUSY.
//  - If WDOG_CYCLES elapse without mul_done: wdog_err<=1 (sticky until reset), req_done[i] pulses, req_out<=0.
//  - The FSM then goes to DRAIN, so a dead multiplier cannot hang requesters.
//  FP_MULT_ARB_WDOG_EN undefined:
//  - No counter; wdog_err is tied to 0; BUSY waits indefinitely for mul_done.
// TESTING
//  1. Single op: req_go[0]=1, left=4'b0110 (1.5), right=4'b0100 (1.0).
//     -> mul_go rises next cycle; req_done[0] after 4 cycles; req_out=4'b0110.
//  2. All four req_go held high, rr_ptr=0.
//     -> grants 0,1,2,3,0 in order, each 5 cycles apart; exactly one req_done per grant.
//  3. Fairness: req 1 held high continuously, req 2 raised while 1 is BUSY.
//     -> next grant goes to 2, then back to 1.
//  4. Change req_left[0] during BUSY.
//     -> mul_left unchanged; result uses the captured operands.
//  5. Assert reset two cycles into BUSY.
//     -> same cycle: mul_go=0, grant=0; no req_done; the next request is served from rr_ptr=0.
//  6. FP_MULT_ARB_WDOG_EN with a multiplier model that never asserts done.
//     -> after 15 BUSY cycles: wdog_err=1, req_done pulses, req_out=0; the arbiter then serves the next requester.

Source files
------------

// File: rtl/std_fp_mult_arbiter.sv
// ----------------------------------------------------------------------------
// std_fp_mult_arbiter
//
// Shares one pipelined fixed-point multiplier (go/done handshake) among
// NUM_REQ requesters. Each requester holds a level go with its packed
// operands. The arbiter picks one round-robin, latches its operands and
// drives the multiplier until done. It then returns the product with a
// one-cycle done pulse to the owner.
//
// Optional feature macro: FP_MULT_ARB_WDOG_EN
//   defined   : a BUSY watchdog forces completion (result 0) and sets a
//               sticky wdog_err after WDOG_CYCLES cycles without mul_done.
//   undefined : no watchdog; wdog_err is tied to 0.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_go    [NUM_REQ]   per-requester level request, held until req_done
//   req_left/right        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_done  [NUM_REQ]   one-hot, one-cycle completion pulse
//   req_out   [WIDTH]     product of the last completed operation
//   grant     [NUM_REQ]   one-hot current owner, 0 when idle
//   mul_left/right        operand registers to the multiplier
//   mul_go                multiplier go
//   mul_out, mul_done     multiplier result and done
//   wdog_err              sticky watchdog timeout flag
//
// State table
//   state | meaning
//   IDLE  | no owner; picks the next requester at or after rr_ptr
//   BUSY  | owner granted, mul_go high, operands frozen until mul_done
//   DRAIN | one cycle with mul_go low so the multiplier's done pipe clears
// ----------------------------------------------------------------------------
module std_fp_mult_arbiter #(
    parameter int WIDTH       = 4,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LAT     = 3,
    parameter int WDOG_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_go,
    input  logic [NUM_REQ*WIDTH-1:0]   req_left,
    input  logic [NUM_REQ*WIDTH-1:0]   req_right,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [WIDTH-1:0]           req_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic [WIDTH-1:0]           mul_left,
    output logic [WIDTH-1:0]           mul_right,
    output logic                       mul_go,
    input  logic [WIDTH-1:0]           mul_out,
    input  logic                       mul_done,
    output logic                       wdog_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MUL_LAT < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("std_fp_mult_arbiter: NUM_REQ must be >= 2, MUL_LAT and WDOG_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]     owner_q,     owner_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;
    logic [NUM_REQ-1:0]   req_done_q,  req_done_d;
    logic [WIDTH-1:0]     req_out_q,   req_out_d;
    logic [WIDTH-1:0]     mul_left_q,  mul_left_d;
    logic [WIDTH-1:0]     mul_right_q, mul_right_d;
    logic                 mul_go_q,    mul_go_d;

`ifdef FP_MULT_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0]      wdog_cnt_q,  wdog_cnt_d;
    logic                 wdog_err_q,  wdog_err_d;
`endif

    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!pick_valid && req_go[IDX_W'(j)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    // Pointer moves past the owner so it ranks last at the next pick.
    logic [IDX_W-1:0]     next_ptr;
    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    logic                 complete;
    logic [WIDTH-1:0]     result;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        req_done_d  = '0;
        req_out_d   = req_out_q;
        mul_left_d  = mul_left_q;
        mul_right_d = mul_right_q;
        mul_go_d    = mul_go_q;
        complete    = 1'b0;
        result      = mul_out;
`ifdef FP_MULT_ARB_WDOG_EN
        wdog_cnt_d  = wdog_cnt_q;
        wdog_err_d  = wdog_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    mul_left_d  = req_left[pick_idx*WIDTH +: WIDTH];
                    mul_right_d = req_right[pick_idx*WIDTH +: WIDTH];
                    mul_go_d    = 1'b1;
                    state_d     = BUSY;
`ifdef FP_MULT_ARB_WDOG_EN
                    // Terminal count reached in the WDOG_CYCLES-th BUSY cycle.
                    wdog_cnt_d  = WD_W'(WDOG_CYCLES - 1);
`endif
                end
            end

            BUSY: begin
                complete = mul_done;
`ifdef FP_MULT_ARB_WDOG_EN
                if (!mul_done) begin
                    if (wdog_cnt_q == '0) begin
                        complete   = 1'b1;
                        result     = '0;
                        wdog_err_d = 1'b1;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q - WD_W'(1);
                    end
                end
`endif
                if (complete) begin
                    req_out_d  = result;
                    req_done_d = NUM_REQ'(1) << owner_q;
                    mul_go_d   = 1'b0;
                    grant_d    = '0;
                    rr_ptr_d   = next_ptr;
                    state_d    = DRAIN;
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mul_go_d = 1'b0;
                grant_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            req_done_q  <= '0;
            req_out_q   <= '0;
            mul_left_q  <= '0;
            mul_right_q <= '0;
            mul_go_q    <= 1'b0;
`ifdef FP_MULT_ARB_WDOG_EN
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            req_done_q  <= req_done_d;
            req_out_q   <= req_out_d;
            mul_left_q  <= mul_left_d;
            mul_right_q <= mul_right_d;
            mul_go_q    <= mul_go_d;
`ifdef FP_MULT_ARB_WDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign req_done  = req_done_q;
    assign req_out   = req_out_q;
    assign mul_left  = mul_left_q;
    assign mul_right = mul_right_q;
    assign mul_go    = mul_go_q;

`ifdef FP_MULT_ARB_WDOG_EN
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_std_fp_mult_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for std_fp_mult_arbiter. The multiplier is a behavioural
// 3-cycle go/done model with 2 fractional bits (product bits [5:2]).
// Expected products are hand-computed and queued as each request is issued.
// A monitor pops and compares on every req_done pulse and every new grant.
// ----------------------------------------------------------------------------
module tb_std_fp_mult_arbiter;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int WD  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_go;
    logic [N*W-1:0]   req_left;
    logic [N*W-1:0]   req_right;
    logic [N-1:0]     req_done;
    logic [W-1:0]     req_out;
    logic [N-1:0]     grant;
    logic [W-1:0]     mul_left;
    logic [W-1:0]     mul_right;
    logic             mul_go;
    logic [W-1:0]     mul_out;
    logic             mul_done;
    logic             wdog_err;

    std_fp_mult_arbiter #(
        .WIDTH(W), .NUM_REQ(N), .MUL_LAT(LAT), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_go(req_go), .req_left(req_left), .req_right(req_right),
        .req_done(req_done), .req_out(req_out), .grant(grant),
        .mul_left(mul_left), .mul_right(mul_right), .mul_go(mul_go),
        .mul_out(mul_out), .mul_done(mul_done), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done in the LAT-th cycle of go being high.
    int           mcnt;
    logic         mdone;
    logic [W-1:0] mres;
    logic         dead = 1'b0;
    logic         spur = 1'b0;
    logic [7:0]   prod_full;
    assign prod_full = {4'b0, mul_left} * {4'b0, mul_right};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt  <= 0;
            mdone <= 1'b0;
            mres  <= '0;
        end else if (!mul_go || mdone) begin
            mcnt  <= 0;
            mdone <= 1'b0;
        end else if (!dead && mcnt == LAT - 2) begin
            mdone <= 1'b1;
            mres  <= prod_full[5:2];
        end else if (!dead) begin
            mcnt  <= mcnt + 1;
        end
    end
    assign mul_out  = mres;
    assign mul_done = mdone | spur;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [N-1:0] vec; logic [W-1:0] out; } sb_t;
    typedef struct { logic [N-1:0] vec; int gap; } gr_t;
    sb_t sb_q[$];
    gr_t gr_q[$];

    task automatic exp_done(input logic [N-1:0] v, input logic [W-1:0] o);
        sb_t e;
        e.vec = v;
        e.out = o;
        sb_q.push_back(e);
    endtask

    task automatic exp_grant(input logic [N-1:0] v, input int gap);
        gr_t e;
        e.vec = v;
        e.gap = gap;
        gr_q.push_back(e);
    endtask

    // Monitor: completions and new grants.
    logic [N-1:0] prev_grant = '0;
    int           last_grant_cyc = 0;
    always @(negedge clk) begin
        if (req_done !== '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: req_done=%b req_out=%b, no completion expected", req_done, req_out);
            end else begin
                chk("done_vec", 32'(req_done), 32'(sb_q[0].vec));
                chk("req_out", 32'(req_out), 32'(sb_q[0].out));
                void'(sb_q.pop_front());
            end
        end
        if (grant !== '0 && prev_grant === '0) begin
            if (gr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: grant=%b, no grant expected", grant);
            end else begin
                chk("grant_vec", 32'(grant), 32'(gr_q[0].vec));
                if (gr_q[0].gap != 0)
                    chk("grant_gap", 32'(cyc - last_grant_cyc), 32'(gr_q[0].gap));
                void'(gr_q.pop_front());
            end
            last_grant_cyc <= cyc;
        end
        prev_grant <= grant;
    end

    task automatic set_op(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        req_left[i*W +: W]  = l;
        req_right[i*W +: W] = r;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_go = '0;
        spur   = 1'b0;
        dead   = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] v, input string name);
        int n = 0;
        while (grant !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(grant), 32'(v));
    endtask

    task automatic wait_done(input logic [N-1:0] v, input string name);
        int n = 0;
        while (req_done !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(req_done), 32'(v));
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ng;
        int n;
        logic [N-1:0] pg;

        req_left  = '0;
        req_right = '0;
        req_go    = '0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rst_grant",    32'(grant),    32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_req_out",  32'(req_out),  32'd0);
        chk("rst_mul_go",   32'(mul_go),   32'd0);
        chk("rst_mul_left", 32'(mul_left), 32'd0);
        chk("rst_mul_right",32'(mul_right),32'd0);
        chk("rst_wdog",     32'(wdog_err), 32'd0);
        do_reset();

        // 1. Single op: 1.5 * 1.0 = 1.5
        @(negedge clk);
        set_op(0, 4'b0110, 4'b0100);
        exp_done(4'b0001, 4'b0110);
        exp_grant(4'b0001, 0);
        req_go = 4'b0001;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("t1_mul_go", 32'(mul_go), 32'd1);
            if (req_done !== '0) begin
                lat = k;
                break;
            end
        end
        chk("t1_latency", 32'(lat), 32'd4);
        req_go = '0;
        wait_sb_empty("t1_drain");

        // 2. All requesters high from rr_ptr=0.
        do_reset();
        set_op(0, 4'b0100, 4'b0100);   // 1.0*1.0 = 1.0
        set_op(1, 4'b1000, 4'b0110);   // 2.0*1.5 = 3.0
        set_op(2, 4'b0010, 4'b0010);   // 0.5*0.5 = 0.25
        set_op(3, 4'b1100, 4'b1000);   // 3.0*2.0 = 6.0 -> truncated 2.0
        exp_done(4'b0001, 4'b0100);
        exp_done(4'b0010, 4'b1100);
        exp_done(4'b0100, 4'b0001);
        exp_done(4'b1000, 4'b1000);
        exp_done(4'b0001, 4'b0100);
        exp_grant(4'b0001, 0);
        exp_grant(4'b0010, LAT + 2);
        exp_grant(4'b0100, LAT + 2);
        exp_grant(4'b1000, LAT + 2);
        exp_grant(4'b0001, LAT + 2);
        req_go = 4'b1111;
        ng = 0;
        n  = 0;
        pg = grant;
        while (ng < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (grant !== '0 && pg === '0) ng++;
            pg = grant;
        end
        chk("t2_grant_count", 32'(ng), 32'd5);
        req_go = '0;
        wait_sb_empty("t2_drain");

        // 3. Fairness: req 1 held, req 2 raised while 1 is busy.
        do_reset();
        set_op(1, 4'b0101, 4'b0100);   // 1.25*1.0 = 1.25
        set_op(2, 4'b0111, 4'b1000);   // 1.75*2.0 = 3.5
        exp_done(4'b0010, 4'b0101);
        exp_done(4'b0100, 4'b1110);
        exp_done(4'b0010, 4'b0101);
        exp_grant(4'b0010, 0);
        exp_grant(4'b0100, LAT + 2);
        exp_grant(4'b0010, LAT + 2);
        req_go = 4'b0010;
        wait_grant(4'b0010, "t3_first_grant");
        @(negedge clk);
        req_go[2] = 1'b1;
        wait_done(4'b0100, "t3_done2");
        req_go[2] = 1'b0;
        wait_grant(4'b0010, "t3_back_to_1");
        req_go[1] = 1'b0;
        wait_sb_empty("t3_drain");

        // 4. Operand change during BUSY is ignored; req_out held at grant.
        @(negedge clk);
        set_op(0, 4'b0110, 4'b1000);   // 1.5*2.0 = 3.0
        exp_done(4'b0001, 4'b1100);
        exp_grant(4'b0001, 0);
        req_go = 4'b0001;
        wait_grant(4'b0001, "t4_grant");
        chk("t4_req_out_hold", 32'(req_out), 32'(4'b0101));
        set_op(0, 4'b1111, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        chk("t4_mul_left",  32'(mul_left),  32'(4'b0110));
        chk("t4_mul_right", 32'(mul_right), 32'(4'b1000));
        req_go = '0;
        wait_sb_empty("t4_drain");

        // 5. Reset two cycles into BUSY; next pick restarts from rr_ptr=0.
        @(negedge clk);
        set_op(2, 4'b0100, 4'b0100);
        exp_grant(4'b0100, 0);
        req_go = 4'b0100;
        wait_grant(4'b0100, "t5_grant");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_mul_go",  32'(mul_go),  32'd0);
        chk("t5_grant",   32'(grant),   32'd0);
        chk("t5_req_out", 32'(req_out), 32'd0);
        req_go = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        set_op(0, 4'b0011, 4'b0100);   // 0.75*1.0 = 0.75
        set_op(1, 4'b1010, 4'b1010);   // 2.5*2.5 = 6.25 -> truncated 2.25
        exp_done(4'b0001, 4'b0011);
        exp_done(4'b0010, 4'b1001);
        exp_grant(4'b0001, 0);
        exp_grant(4'b0010, LAT + 2);
        req_go = 4'b0011;
        wait_done(4'b0001, "t5_done0");
        req_go[0] = 1'b0;
        wait_grant(4'b0010, "t5_grant1");
        req_go[1] = 1'b0;
        wait_sb_empty("t5_drain");

        // Spurious mul_done outside BUSY is ignored.
        repeat (2) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_grant",   32'(grant),   32'd0);
        chk("spur_req_out", 32'(req_out), 32'(4'b1001));
        chk("spur_mul_go",  32'(mul_go),  32'd0);
        repeat (3) @(negedge clk);

`ifdef FP_MULT_ARB_WDOG_EN
        // 6. Dead multiplier: watchdog forces completion with 0.
        dead = 1'b1;
        set_op(3, 4'b0101, 4'b0101);
        exp_done(4'b1000, 4'b0000);
        exp_grant(4'b1000, 0);
        req_go = 4'b1000;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (req_done !== '0) begin
                lat = k;
                break;
            end
        end
        chk("t6_wdog_latency", 32'(lat), 32'(WD + 1));
        chk("t6_wdog_err", 32'(wdog_err), 32'd1);
        req_go = '0;
        dead   = 1'b0;
        set_op(0, 4'b0110, 4'b0100);
        exp_done(4'b0001, 4'b0110);
        exp_grant(4'b0001, 0);
        req_go = 4'b0001;
        wait_done(4'b0001, "t6_next_served");
        req_go = '0;
        wait_sb_empty("t6_drain");
        chk("t6_wdog_sticky", 32'(wdog_err), 32'd1);
`else
        chk("wdog_tied_low", 32'(wdog_err), 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("end_sb_empty",    32'(sb_q.size()), 32'd0);
        chk("end_grant_empty", 32'(gr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
